// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Single-owner arbiter that shares the byte-serial memory controller port
// between the instruction cache (ic_*) and the load/store buffer (ls_*).
// One request at a time is latched onto mc_*. It is held as a level until
// mc_done arrives. A one-cycle ack then returns the data, and one idle
// turnaround cycle follows before the next arbitration.
//
// Arbitration: the LSB wins by default. A saturating starve counter counts LSB
// grants made while a fetch is waiting. Once it reaches STARVE_LIMIT, the
// icache wins the next contested arbitration.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   rdy             global ready; low freezes every register
//   ic_req/ic_addr  icache fetch request (level) and address
//   ic_ack/ic_data  one-cycle fetch completion pulse and instruction word
//   ls_req/ls_wr/ls_addr/ls_wdata/ls_len   LSB request (level), len 1/2/4
//   ls_ack/ls_rdata one-cycle LSB completion pulse, zero-masked load data
//   mc_valid/mc_wr/mc_addr/mc_wdata/mc_len latched request to the controller
//   mc_done/mc_rdata completion pulse and read data from the controller
//
// Optional build macro MEM_ARB_STATS_EN adds the statistics outputs
// stat_ic_grants, stat_ls_grants and stat_conflict_cycles (CNT_W bits each).
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ack,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_len,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_len,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ic_grants,
  output logic [CNT_W-1:0] stat_ls_grants,
  output logic [CNT_W-1:0] stat_conflict_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IC = 3'd1,
    BUSY_LS = 3'd2,
    ACK     = 3'd3,
    TURN    = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  // Lengths other than 1 and 2 bytes are treated as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    logic [2:0] res;
    case (len)
      3'd1:    res = 3'd1;
      3'd2:    res = 3'd2;
      default: res = 3'd4;
    endcase
    return res;
  endfunction

  // Zero the bytes above the access length; sign extension is the LSB's job.
  function automatic logic [31:0] mask_rdata(input logic [31:0] data,
                                             input logic [2:0]  len);
    logic [31:0] res;
    case (len)
      3'd1:    res = {24'd0, data[7:0]};
      3'd2:    res = {16'd0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  state_t      state_r;
  logic [3:0]  starve_r;

  state_t      state_nx_s;
  logic [3:0]  starve_nx_s;
  logic        grant_ic_s;
  logic        grant_ls_s;
  logic        mc_valid_nx_s;
  logic        mc_wr_nx_s;
  logic [31:0] mc_addr_nx_s;
  logic [31:0] mc_wdata_nx_s;
  logic [2:0]  mc_len_nx_s;
  logic        ic_ack_nx_s;
  logic [31:0] ic_data_nx_s;
  logic        ls_ack_nx_s;
  logic [31:0] ls_rdata_nx_s;

  // Next-state, arbitration and next output-register values.
  always_comb begin
    state_nx_s    = state_r;
    starve_nx_s   = starve_r;
    grant_ic_s    = 1'b0;
    grant_ls_s    = 1'b0;
    mc_valid_nx_s = mc_valid;
    mc_wr_nx_s    = mc_wr;
    mc_addr_nx_s  = mc_addr;
    mc_wdata_nx_s = mc_wdata;
    mc_len_nx_s   = mc_len;
    ic_ack_nx_s   = ic_ack;
    ic_data_nx_s  = ic_data;
    ls_ack_nx_s   = ls_ack;
    ls_rdata_nx_s = ls_rdata;

    case (state_r)
      IDLE: begin
        if (ic_req && (!ls_req || (starve_r == LIMIT_C))) begin
          grant_ic_s    = 1'b1;
          state_nx_s    = BUSY_IC;
          starve_nx_s   = 4'd0;
          mc_valid_nx_s = 1'b1;
          mc_wr_nx_s    = 1'b0;
          mc_addr_nx_s  = ic_addr;
          mc_wdata_nx_s = 32'd0;
          mc_len_nx_s   = 3'd4;
        end else if (ls_req) begin
          grant_ls_s    = 1'b1;
          state_nx_s    = BUSY_LS;
          mc_valid_nx_s = 1'b1;
          mc_wr_nx_s    = ls_wr;
          mc_addr_nx_s  = ls_addr;
          mc_wdata_nx_s = ls_wdata;
          mc_len_nx_s   = norm_len(ls_len);
          // Only grants that make a waiting fetch wait longer are counted.
          if (ic_req) begin
            if (starve_r != LIMIT_C) begin
              starve_nx_s = starve_r + 4'd1;
            end else begin
              starve_nx_s = starve_r;
            end
          end else begin
            starve_nx_s = 4'd0;
          end
        end else begin
          starve_nx_s = 4'd0;
        end
      end

      BUSY_IC: begin
        // Completion beats withdrawal when both land in the same cycle.
        if (mc_done) begin
          mc_valid_nx_s = 1'b0;
          ic_ack_nx_s   = 1'b1;
          ic_data_nx_s  = mc_rdata;
          state_nx_s    = ACK;
        end else if (!ic_req) begin
          mc_valid_nx_s = 1'b0;
          state_nx_s    = TURN;
        end else begin
          state_nx_s    = BUSY_IC;
        end
      end

      BUSY_LS: begin
        // A store is never aborted; only a withdrawn load is dropped.
        if (mc_done) begin
          mc_valid_nx_s = 1'b0;
          ls_ack_nx_s   = 1'b1;
          ls_rdata_nx_s = mask_rdata(mc_rdata, mc_len);
          state_nx_s    = ACK;
        end else if (!ls_req && !mc_wr) begin
          mc_valid_nx_s = 1'b0;
          state_nx_s    = TURN;
        end else begin
          state_nx_s    = BUSY_LS;
        end
      end

      ACK: begin
        ic_ack_nx_s = 1'b0;
        ls_ack_nx_s = 1'b0;
        state_nx_s  = TURN;
      end

      TURN: begin
        state_nx_s = IDLE;
      end

      default: begin
        state_nx_s    = IDLE;
        mc_valid_nx_s = 1'b0;
        ic_ack_nx_s   = 1'b0;
        ls_ack_nx_s   = 1'b0;
      end
    endcase
  end

  // State, starve counter and output registers; rdy low freezes them all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      starve_r <= 4'd0;
      mc_valid <= 1'b0;
      mc_wr    <= 1'b0;
      mc_addr  <= 32'd0;
      mc_wdata <= 32'd0;
      mc_len   <= 3'd0;
      ic_ack   <= 1'b0;
      ic_data  <= 32'd0;
      ls_ack   <= 1'b0;
      ls_rdata <= 32'd0;
    end else if (rdy) begin
      state_r  <= state_nx_s;
      starve_r <= starve_nx_s;
      mc_valid <= mc_valid_nx_s;
      mc_wr    <= mc_wr_nx_s;
      mc_addr  <= mc_addr_nx_s;
      mc_wdata <= mc_wdata_nx_s;
      mc_len   <= mc_len_nx_s;
      ic_ack   <= ic_ack_nx_s;
      ic_data  <= ic_data_nx_s;
      ls_ack   <= ls_ack_nx_s;
      ls_rdata <= ls_rdata_nx_s;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic ic_wait_s;
  logic ls_wait_s;

  // A request is waiting when it is asserted but neither granted this cycle
  // nor already the transfer in flight.
  always_comb begin
    ic_wait_s = ic_req && !grant_ic_s && (state_r != BUSY_IC);
    ls_wait_s = ls_req && !grant_ls_s && (state_r != BUSY_LS);
  end

  // Wrapping statistics counters, frozen with the rest of the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ic_grants       <= '0;
      stat_ls_grants       <= '0;
      stat_conflict_cycles <= '0;
    end else if (rdy) begin
      if (grant_ic_s) begin
        stat_ic_grants <= stat_ic_grants + CNT_W'(1);
      end
      if (grant_ls_s) begin
        stat_ls_grants <= stat_ls_grants + CNT_W'(1);
      end
      if (ic_wait_s || ls_wait_s) begin
        stat_conflict_cycles <= stat_conflict_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter plus
// hand-written sequences for starvation, withdrawal, rdy freeze and async reset.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'd0;
  logic        ic_ack;
  logic [31:0] ic_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic [2:0]  ls_len = 3'd0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        mc_valid;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [2:0]  mc_len;
  logic        mc_done = 1'b0;
  logic [31:0] mc_rdata = 32'd0;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_ic_grants;
  logic [31:0] stat_ls_grants;
  logic [31:0] stat_conflict_cycles;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] IC_A = 32'h0000_1000;
  localparam logic [31:0] LS_A = 32'h0000_2000;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_len(ls_len), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_len(mc_len), .mc_done(mc_done), .mc_rdata(mc_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ic_grants(stat_ic_grants), .stat_ls_grants(stat_ls_grants),
    .stat_conflict_cycles(stat_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ls_req;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_len;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic        e_valid;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [2:0]  e_len;
    logic        e_ic_ack;
    logic [31:0] e_ic_data;
    logic        e_ls_ack;
    logic [31:0] e_ls_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic i_ic, input logic [31:0] i_ica, input logic i_ls, input logic i_wr,
    input logic [31:0] i_lsa, input logic [31:0] i_wd, input logic [2:0] i_len,
    input logic i_done, input logic [31:0] i_rd,
    input logic x_v, input logic x_wr, input logic [31:0] x_a, input logic [31:0] x_wd,
    input logic [2:0] x_len, input logic x_ica, input logic [31:0] x_icd,
    input logic x_lsa, input logic [31:0] x_lsd);
    vec_t v;
    v.ic_req = i_ic;   v.ic_addr = i_ica; v.ls_req = i_ls; v.ls_wr = i_wr;
    v.ls_addr = i_lsa; v.ls_wdata = i_wd; v.ls_len = i_len;
    v.mc_done = i_done; v.mc_rdata = i_rd;
    v.e_valid = x_v;   v.e_wr = x_wr;     v.e_addr = x_a;  v.e_wdata = x_wd;
    v.e_len = x_len;   v.e_ic_ack = x_ica; v.e_ic_data = x_icd;
    v.e_ls_ack = x_lsa; v.e_ls_rdata = x_lsd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until mc_valid rises, bounded; returns the number of steps taken.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (mc_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk({name, "_valid_seen"}, {31'd0, mc_valid}, 32'd1);
  endtask

  // Wait for the next grant, check who won and optionally complete it.
  task automatic grant_one(input string name, input bit exp_ls, input bit complete);
    int n;
    wait_valid(name, n);
    chk({name, "_owner"}, mc_addr, exp_ls ? LS_A : IC_A);
    if (complete) begin
      step();
      mc_done  = 1'b1;
      mc_rdata = 32'h0BAD_F00D;
      step();
      mc_done  = 1'b0;
      chk({name, "_ic_ack"}, {31'd0, ic_ack}, {31'd0, !exp_ls});
      chk({name, "_ls_ack"}, {31'd0, ls_ack}, {31'd0, exp_ls});
    end
  endtask

  task automatic idle_inputs();
    ic_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; mc_done = 1'b0;
  endtask

  initial begin
    int n;
    // ---------------- vector table ----------------
    // single fetch, mc_done after 5 cycles
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'd0, 0, 0,
                        1, 0, 32'h100, 0, 3'd4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 3'd0, 1, 32'h00A0_0093,
                      0, 0, 0, 0, 3'd0, 1, 32'h00A0_0093, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // load byte
    vecs.push_back(mk(0, 0, 1, 0, 32'h2004, 0, 3'd1, 0, 0,
                      1, 0, 32'h2004, 0, 3'd1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h2004, 0, 3'd1, 1, 32'hDEAD_BEEF,
                      0, 0, 0, 0, 3'd0, 0, 0, 1, 32'h0000_00EF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // load halfword
    vecs.push_back(mk(0, 0, 1, 0, 32'h3000, 0, 3'd2, 0, 0,
                      1, 0, 32'h3000, 0, 3'd2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h3000, 0, 3'd2, 1, 32'hCAFE_F00D,
                      0, 0, 0, 0, 3'd0, 0, 0, 1, 32'h0000_F00D));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // invalid length 3 -> word
    vecs.push_back(mk(0, 0, 1, 0, 32'h40, 0, 3'd3, 0, 0,
                      1, 0, 32'h40, 0, 3'd4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h40, 0, 3'd3, 1, 32'h1122_3344,
                      0, 0, 0, 0, 3'd0, 0, 0, 1, 32'h1122_3344));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // invalid length 0 -> word
    vecs.push_back(mk(0, 0, 1, 0, 32'h44, 0, 3'd0, 0, 0,
                      1, 0, 32'h44, 0, 3'd4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h44, 0, 3'd0, 1, 32'h89AB_CDEF,
                      0, 0, 0, 0, 3'd0, 0, 0, 1, 32'h89AB_CDEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // word store
    vecs.push_back(mk(0, 0, 1, 1, 32'h50, 32'h1234_5678, 3'd4, 0, 0,
                      1, 1, 32'h50, 32'h1234_5678, 3'd4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h50, 32'h1234_5678, 3'd4, 1, 0,
                      0, 0, 0, 0, 3'd0, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    // stray mc_done in IDLE is ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 1, 32'hFFFF_FFFF,
                      0, 0, 0, 0, 3'd0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mc_valid", {31'd0, mc_valid}, 32'd0);
    chk("reset_ic_ack", {31'd0, ic_ack}, 32'd0);
    chk("reset_ls_ack", {31'd0, ls_ack}, 32'd0);
    chk("reset_mc_addr", mc_addr, 32'd0);
    chk("reset_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b1;

    // ---------------- table loop ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      ic_req = vecs[i].ic_req;   ic_addr = vecs[i].ic_addr;
      ls_req = vecs[i].ls_req;   ls_wr = vecs[i].ls_wr;
      ls_addr = vecs[i].ls_addr; ls_wdata = vecs[i].ls_wdata; ls_len = vecs[i].ls_len;
      mc_done = vecs[i].mc_done; mc_rdata = vecs[i].mc_rdata;
      step();
      chk($sformatf("vec%0d_mc_valid", i), {31'd0, mc_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_ic_ack", i), {31'd0, ic_ack}, {31'd0, vecs[i].e_ic_ack});
      chk($sformatf("vec%0d_ls_ack", i), {31'd0, ls_ack}, {31'd0, vecs[i].e_ls_ack});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_mc_wr", i), {31'd0, mc_wr}, {31'd0, vecs[i].e_wr});
        chk($sformatf("vec%0d_mc_addr", i), mc_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d_mc_len", i), {29'd0, mc_len}, {29'd0, vecs[i].e_len});
        if (vecs[i].e_wr)
          chk($sformatf("vec%0d_mc_wdata", i), mc_wdata, vecs[i].e_wdata);
      end
      if (vecs[i].e_ic_ack)
        chk($sformatf("vec%0d_ic_data", i), ic_data, vecs[i].e_ic_data);
      if (vecs[i].e_ls_ack)
        chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, vecs[i].e_ls_rdata);
    end
    idle_inputs();

    // ---------------- priority and starvation ----------------
    ic_req = 1'b1; ic_addr = IC_A;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = LS_A; ls_len = 3'd4;
    for (int g = 0; g < 10; g++)
      grant_one($sformatf("starve_g%0d", g), (g % 5) != 4, 1'b1);
    // Minimum gap between consecutive mc_valid rises.
    grant_one("spacing_pre", 1'b1, 1'b1);
    wait_valid("spacing", n);
    chk("spacing_ge3", {31'd0, n >= 3}, 32'd1);
    step();
    mc_done = 1'b1;
    step();
    mc_done = 1'b0;
    idle_inputs();
    repeat (3) step();

    // ---------------- store survives withdrawal ----------------
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h60; ls_wdata = 32'h1234_5678; ls_len = 3'd4;
    wait_valid("st_flush", n);
    chk("st_flush_wdata", mc_wdata, 32'h1234_5678);
    step();
    ls_req = 1'b0;
    step();
    chk("st_flush_hold1", {31'd0, mc_valid}, 32'd1);
    step();
    chk("st_flush_hold2", {31'd0, mc_valid}, 32'd1);
    mc_done = 1'b1;
    step();
    mc_done = 1'b0;
    chk("st_flush_ls_ack", {31'd0, ls_ack}, 32'd1);
    chk("st_flush_valid_drop", {31'd0, mc_valid}, 32'd0);
    ls_wr = 1'b0;
    repeat (2) step();

    // ---------------- fetch withdrawal ----------------
    ic_req = 1'b1; ic_addr = 32'h700;
    wait_valid("ic_flush", n);
    step();
    ic_req = 1'b0;
    step();
    chk("ic_flush_valid_drop", {31'd0, mc_valid}, 32'd0);
    chk("ic_flush_no_ack", {31'd0, ic_ack}, 32'd0);
    mc_done = 1'b1;  // late completion lands in TURN and is ignored
    step();
    mc_done = 1'b0;
    chk("ic_flush_late_done", {31'd0, ic_ack}, 32'd0);
    step();

    // ---------------- load withdrawal ----------------
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'hB00; ls_len = 3'd4;
    wait_valid("ld_flush", n);
    ls_req = 1'b0;
    step();
    chk("ld_flush_valid_drop", {31'd0, mc_valid}, 32'd0);
    step();
    chk("ld_flush_no_ack", {31'd0, ls_ack}, 32'd0);
    step();

    // ---------------- withdrawal coincident with mc_done ----------------
    ic_req = 1'b1; ic_addr = 32'hA00;
    wait_valid("wd_done", n);
    ic_req = 1'b0; mc_done = 1'b1; mc_rdata = 32'hABCD_0123;
    step();
    mc_done = 1'b0;
    chk("wd_done_ic_ack", {31'd0, ic_ack}, 32'd1);
    chk("wd_done_ic_data", ic_data, 32'hABCD_0123);
    repeat (2) step();

    // ---------------- rdy low during ACK ----------------
    ic_req = 1'b1; ic_addr = 32'h800;
    wait_valid("rdy", n);
    mc_done = 1'b1; mc_rdata = 32'h55AA_55AA;
    step();
    mc_done = 1'b0; ic_req = 1'b0; rdy = 1'b0;
    chk("rdy_ack_start", {31'd0, ic_ack}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rdy_hold%0d_ack", k), {31'd0, ic_ack}, 32'd1);
      chk($sformatf("rdy_hold%0d_valid", k), {31'd0, mc_valid}, 32'd0);
    end
    chk("rdy_hold_data", ic_data, 32'h55AA_55AA);
    rdy = 1'b1;
    step();
    chk("rdy_ack_release", {31'd0, ic_ack}, 32'd0);
    repeat (2) step();

    // ---------------- async reset mid BUSY_LS ----------------
    ic_req = 1'b1; ic_addr = IC_A;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = LS_A; ls_len = 3'd4;
    for (int g = 0; g < 3; g++)
      grant_one($sformatf("rst_pre_g%0d", g), 1'b1, 1'b1);
    grant_one("rst_pre_g3", 1'b1, 1'b0);  // starve counter now at the limit
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, mc_valid}, 32'd0);
    chk("async_rst_ls_ack", {31'd0, ls_ack}, 32'd0);
    chk("async_rst_ic_ack", {31'd0, ic_ack}, 32'd0);
    chk("async_rst_addr", mc_addr, 32'd0);
    #2;
    rst = 1'b1;
    // With the counter cleared the LSB wins again.
    grant_one("rst_post", 1'b1, 1'b1);
    idle_inputs();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
